// File: rtl/spi_wb_master_pkg.sv
// Shared register map, CTRL bit positions and sequencer state encoding
// for the SPI-core Wishbone command sequencer.
package spi_wbm_pkg;

  localparam logic [4:0] ADR_RX0     = 5'h00;
  localparam logic [4:0] ADR_TX0     = 5'h00;
  localparam logic [4:0] ADR_CTRL    = 5'h10;
  localparam logic [4:0] ADR_DIVIDER = 5'h14;
  localparam logic [4:0] ADR_SS      = 5'h18;

  localparam int CTRL_GO_BSY = 8;
  localparam int CTRL_RX_NEG = 9;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_LSB    = 11;
  localparam int CTRL_IE     = 12;
  localparam int CTRL_ASS    = 13;

  typedef enum logic [2:0] {
    S_INIT_DIV,
    S_IDLE,
    S_WR_TX,
    S_WR_SS,
    S_WR_CTRL,
    S_WAIT_DONE,
    S_RD_RX,
    S_RESP
  } state_t;

  function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic lsb,
                                            input logic ie, input logic ass);
    logic [31:0] v;
    v              = 32'd0;
    v[6:0]         = len;
    v[CTRL_GO_BSY] = 1'b1;
    v[CTRL_RX_NEG] = 1'b0;
    v[CTRL_TX_NEG] = 1'b1;
    v[CTRL_LSB]    = lsb;
    v[CTRL_IE]     = ie;
    v[CTRL_ASS]    = ass;
    return v;
  endfunction

endpackage

// File: rtl/spi_wb_master_if.sv
// Command/response port and Wishbone initiator port of the sequencer.
interface spi_wb_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_data_i;
  logic [6:0]  cmd_len_i;
  logic [7:0]  cmd_ss_i;
  logic        cmd_lsb_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_int_i;

  modport master (
    input  cmd_valid_i, cmd_data_i, cmd_len_i, cmd_ss_i, cmd_lsb_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_int_i
  );

  modport slave (
    output cmd_valid_i, cmd_data_i, cmd_len_i, cmd_ss_i, cmd_lsb_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_int_i
  );
endinterface

// File: rtl/spi_wbm_xfer.sv
// Single Wishbone classic transaction: cyc/stb held from start until ack, err
// or ACK_TIMEOUT cycles; done/err/rdat are valid combinationally on the final cycle.
module spi_wbm_xfer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [4:0]  i_adr,
  input  logic [31:0] i_wdat,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  logic        r_cyc;
  logic        r_we;
  logic [4:0]  r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic [15:0] r_cnt;
  logic        w_timeout;

  assign w_timeout = (r_cnt >= TO_LAST);
  assign o_done    = r_cyc & (i_wb_ack | i_wb_err | w_timeout);
  // err beats a simultaneous ack; a late ack on the final timeout cycle still counts
  assign o_err     = r_cyc & (i_wb_err | (w_timeout & ~i_wb_ack));
  assign o_rdat    = i_wb_dat;

  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_cyc;
  assign o_wb_we  = r_we;
  assign o_wb_adr = r_adr;
  assign o_wb_dat = r_dat;
  assign o_wb_sel = r_sel;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= 5'd0;
      r_dat <= 32'd0;
      r_sel <= 4'd0;
      r_cnt <= 16'd0;
    end else if (r_cyc) begin
      if (o_done) begin
        r_cyc <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end else if (i_start) begin
      r_cyc <= 1'b1;
      r_we  <= i_we;
      r_adr <= i_adr;
      r_dat <= i_wdat;
      r_sel <= 4'hF;
      r_cnt <= 16'd0;
    end
  end

endmodule

// File: rtl/spi_wb_master.sv
// Command sequencer driving the SPI core registers: DIVIDER once, then TX0/SS/CTRL/wait/RX0.
// SPI_WBM_IRQ_EN: wait on wb_int_i instead of polling CTRL.GO_BSY.
module spi_wb_master
  import spi_wbm_pkg::*;
#(
  parameter logic [15:0] DIVIDER_VAL = 16'd4,
  parameter int          ACK_TIMEOUT = 16,
  parameter logic        ASS_EN      = 1'b1
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  spi_wb_master_if.master  bus
);

`ifdef SPI_WBM_IRQ_EN
  localparam logic IE_VAL = 1'b1;
`else
  localparam logic IE_VAL = 1'b0;
`endif

  state_t      r_state;
  logic        r_div_done;
  logic        r_have_cmd;
  logic        r_issued;
  logic        r_cmd_rdy;
  logic        r_rsp_vld;
  logic        r_rsp_err;
  logic [31:0] r_rsp_dat;
  logic [31:0] r_data;
  logic [6:0]  r_len;
  logic [7:0]  r_ss;
  logic        r_lsb;

  logic        w_bus;
  logic        w_we;
  logic [4:0]  w_adr;
  logic [31:0] w_wdat;
  logic        w_start;
  logic        w_done;
  logic        w_err;
  logic [31:0] w_rdat;

  always_comb begin
    w_bus  = 1'b0;
    w_we   = 1'b0;
    w_adr  = 5'd0;
    w_wdat = 32'd0;
    case (r_state)
      S_INIT_DIV:  begin w_bus = 1'b1; w_we = 1'b1; w_adr = ADR_DIVIDER; w_wdat = {16'd0, DIVIDER_VAL}; end
      S_WR_TX:     begin w_bus = 1'b1; w_we = 1'b1; w_adr = ADR_TX0;     w_wdat = r_data; end
      S_WR_SS:     begin w_bus = 1'b1; w_we = 1'b1; w_adr = ADR_SS;      w_wdat = {24'd0, r_ss}; end
      S_WR_CTRL:   begin
        w_bus  = 1'b1;
        w_we   = 1'b1;
        w_adr  = ADR_CTRL;
        w_wdat = ctrl_word(r_len, r_lsb, IE_VAL, ASS_EN);
      end
`ifndef SPI_WBM_IRQ_EN
      S_WAIT_DONE: begin w_bus = 1'b1; w_adr = ADR_CTRL; end
`endif
      S_RD_RX:     begin w_bus = 1'b1; w_adr = ADR_RX0; end
      default:     ;
    endcase
  end

  // Each bus state launches exactly one transaction; a poll re-arms by clearing r_issued
  assign w_start = w_bus & ~r_issued;

  spi_wbm_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_i),
    .i_start  (w_start),
    .i_we     (w_we),
    .i_adr    (w_adr),
    .i_wdat   (w_wdat),
    .o_done   (w_done),
    .o_err    (w_err),
    .o_rdat   (w_rdat),
    .o_wb_cyc (bus.wb_cyc_o),
    .o_wb_stb (bus.wb_stb_o),
    .o_wb_we  (bus.wb_we_o),
    .o_wb_adr (bus.wb_adr_o),
    .o_wb_dat (bus.wb_dat_o),
    .o_wb_sel (bus.wb_sel_o),
    .i_wb_dat (bus.wb_dat_i),
    .i_wb_ack (bus.wb_ack_i),
    .i_wb_err (bus.wb_err_i)
  );

`ifndef SPI_WBM_IRQ_EN
  logic w_unused;
  assign w_unused = bus.wb_int_i;
`endif

  assign bus.cmd_ready_o = r_cmd_rdy;
  assign bus.rsp_valid_o = r_rsp_vld;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_data_o  = r_rsp_dat;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state    <= S_INIT_DIV;
      r_div_done <= 1'b0;
      r_have_cmd <= 1'b0;
      r_issued   <= 1'b0;
      r_cmd_rdy  <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_dat  <= 32'd0;
      r_data     <= 32'd0;
      r_len      <= 7'd0;
      r_ss       <= 8'd0;
      r_lsb      <= 1'b0;
    end else begin
      if (w_start) r_issued <= 1'b1;
      if (w_done)  r_issued <= 1'b0;

      // A failed transaction while a command is pending ends it with an error response
      if (w_done && w_err && (r_state != S_INIT_DIV || r_have_cmd)) begin
        r_state   <= S_RESP;
        r_rsp_vld <= 1'b1;
        r_rsp_err <= 1'b1;
        r_rsp_dat <= 32'd0;
      end else begin
        case (r_state)
          S_INIT_DIV: if (w_done) begin
            r_div_done <= ~w_err;
            if (r_have_cmd && !w_err) begin
              r_state <= S_WR_TX;
            end else begin
              r_state   <= S_IDLE;
              r_cmd_rdy <= 1'b1;
            end
          end
          S_IDLE: if (bus.cmd_valid_i) begin
            r_data     <= bus.cmd_data_i;
            r_len      <= bus.cmd_len_i;
            r_ss       <= bus.cmd_ss_i;
            r_lsb      <= bus.cmd_lsb_i;
            r_have_cmd <= 1'b1;
            r_cmd_rdy  <= 1'b0;
            r_state    <= r_div_done ? S_WR_TX : S_INIT_DIV;
          end
          S_WR_TX:   if (w_done) r_state <= S_WR_SS;
          S_WR_SS:   if (w_done) r_state <= S_WR_CTRL;
          S_WR_CTRL: if (w_done) r_state <= S_WAIT_DONE;
`ifdef SPI_WBM_IRQ_EN
          S_WAIT_DONE: if (bus.wb_int_i) r_state <= S_RD_RX;
`else
          S_WAIT_DONE: if (w_done && !w_rdat[CTRL_GO_BSY]) r_state <= S_RD_RX;
`endif
          S_RD_RX: if (w_done) begin
            r_state   <= S_RESP;
            r_rsp_vld <= 1'b1;
            r_rsp_err <= 1'b0;
            r_rsp_dat <= w_rdat;
          end
          S_RESP: begin
            r_state    <= S_IDLE;
            r_cmd_rdy  <= 1'b1;
            r_have_cmd <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_dat  <= 32'd0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_wb_master.sv
// Directed bench for spi_wb_master with a loop-back SPI register slave model.
module tb_spi_wb_master;

  typedef struct {
    logic [4:0]  adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_wb_master_if bus();

  spi_wb_master dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int polls_seen = 0;
  int busy_until = 0;
  bit noack_tx = 1'b0;
  bit err_ss = 1'b0;
  logic [31:0] rx_reg = 32'd0;
  txn_t log_q[$];
  int rsp_cnt = 0;
  logic [31:0] rsp_dat = 32'd0;
  logic rsp_err = 1'b0;
  int rsp_cycle = 0;
  bit prev_cyc = 1'b0;
  int run_len = 0;
  int last_len = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave: zero-wait ack, TX0 loops back into RX0, CTRL reports busy until busy_until polls
  always_comb begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'd0;
    bus.wb_int_i = 1'b0;
    if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1) begin
      if (!(noack_tx && bus.wb_we_o && bus.wb_adr_o == 5'h00)) bus.wb_ack_i = 1'b1;
      if (err_ss && bus.wb_we_o && bus.wb_adr_o == 5'h18) bus.wb_err_i = 1'b1;
      if (!bus.wb_we_o) begin
        if (bus.wb_adr_o == 5'h10) bus.wb_dat_i = {23'd0, (polls_seen < busy_until), 8'd0};
        else bus.wb_dat_i = rx_reg;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.wb_cyc_o === 1'b1 && bus.wb_ack_i && !bus.wb_err_i) begin
      if (bus.wb_we_o && bus.wb_adr_o == 5'h00) rx_reg <= bus.wb_dat_o;
      if (!bus.wb_we_o && bus.wb_adr_o == 5'h10) polls_seen <= polls_seen + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.wb_cyc_o === 1'b1) begin
      if (!prev_cyc) begin
        log_q.push_back('{bus.wb_adr_o, bus.wb_we_o, bus.wb_dat_o, bus.wb_sel_o});
        run_len = 1;
      end else begin
        run_len = run_len + 1;
      end
    end else if (prev_cyc) begin
      last_len = run_len;
    end
    prev_cyc = (bus.wb_cyc_o === 1'b1);
    if (bus.rsp_valid_o === 1'b1) begin
      rsp_cnt   = rsp_cnt + 1;
      rsp_dat   = bus.rsp_data_o;
      rsp_err   = bus.rsp_err_o;
      rsp_cycle = cyc_cnt;
    end
  end

  task automatic send_cmd(input logic [31:0] d, input logic [6:0] len, input logic [7:0] ss,
                          input logic lsb, output int acc);
    int n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_wait got=%b want=1", bus.cmd_ready_o);
    end
    bus.cmd_valid_i = 1'b1;
    bus.cmd_data_i  = d;
    bus.cmd_len_i   = len;
    bus.cmd_ss_i    = ss;
    bus.cmd_lsb_i   = lsb;
    acc = cyc_cnt;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_data_i  = 32'hDEADBEEF;
    bus.cmd_len_i   = 7'h7F;
    bus.cmd_ss_i    = 8'hFF;
    bus.cmd_lsb_i   = ~lsb;
  endtask

  task automatic wait_rsp(input int base, input int max);
    int n = 0;
    while (rsp_cnt == base && n < max) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_cnt != base + 1) begin
      failures++;
      $display("FAIL rsp_count got=%0d want=%0d", rsp_cnt - base, 1);
    end
  endtask

  task automatic test_reset();
    logic [78:0] outs;
    int base;
    txn_t e;
    repeat (3) @(negedge clk);
    outs = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o,
            bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o};
    checks++;
    if (outs !== 79'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    base = log_q.size();
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (log_q.size() - base != 1) begin
      failures++;
      $display("FAIL init_txn_count got=%0d want=1", log_q.size() - base);
    end else begin
      e = log_q[base];
      checks++;
      if ({e.adr, e.we, e.dat, e.sel} !== {5'h14, 1'b1, 32'h4, 4'hF}) begin
        failures++;
        $display("FAIL init_divider got adr=%h we=%b dat=%h sel=%h want 14/1/4/f", e.adr, e.we, e.dat, e.sel);
      end
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL init_ready got=%b want=1", bus.cmd_ready_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (log_q.size() - base != 1) begin
      failures++;
      $display("FAIL idle_quiet got=%0d want=1", log_q.size() - base);
    end
  endtask

  task automatic test_basic();
    int base, rb, acc;
    txn_t e;
    base = log_q.size();
    rb = rsp_cnt;
    send_cmd(32'hA5, 7'd8, 8'h01, 1'b0, acc);
    wait_rsp(rb, 100);
    checks++;
    if (log_q.size() - base != 5) begin
      failures++;
      $display("FAIL basic_txn_count got=%0d want=5", log_q.size() - base);
    end else begin
      e = log_q[base];
      checks++;
      if ({e.adr, e.we, e.dat} !== {5'h00, 1'b1, 32'hA5}) begin
        failures++;
        $display("FAIL basic_tx0 got adr=%h we=%b dat=%h want 00/1/a5", e.adr, e.we, e.dat);
      end
      e = log_q[base + 1];
      checks++;
      if ({e.adr, e.we, e.dat} !== {5'h18, 1'b1, 32'h01}) begin
        failures++;
        $display("FAIL basic_ss got adr=%h we=%b dat=%h want 18/1/01", e.adr, e.we, e.dat);
      end
      e = log_q[base + 2];
      checks++;
      if ({e.adr, e.we, e.dat} !== {5'h10, 1'b1, 32'h2508}) begin
        failures++;
        $display("FAIL basic_ctrl got adr=%h we=%b dat=%h want 10/1/2508", e.adr, e.we, e.dat);
      end
      e = log_q[base + 4];
      checks++;
      if ({e.adr, e.we} !== {5'h00, 1'b0}) begin
        failures++;
        $display("FAIL basic_rx0 got adr=%h we=%b want 00/0", e.adr, e.we);
      end
    end
    checks++;
    if ({rsp_err, rsp_dat} !== {1'b0, 32'hA5}) begin
      failures++;
      $display("FAIL basic_rsp got err=%b dat=%h want 0/a5", rsp_err, rsp_dat);
    end
    checks++;
    if (rsp_cycle - acc != 11) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=11", rsp_cycle - acc);
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready_after got=%b want=1", bus.cmd_ready_o);
    end
  endtask

  task automatic test_poll();
    int base, rb, acc, nctrl;
    txn_t e;
    base = log_q.size();
    rb = rsp_cnt;
    busy_until = polls_seen + 3;
    send_cmd(32'h3C, 7'd8, 8'h02, 1'b1, acc);
    wait_rsp(rb, 100);
    nctrl = 0;
    for (int i = base; i < log_q.size(); i++)
      if (!log_q[i].we && log_q[i].adr == 5'h10) nctrl++;
    checks++;
    if (nctrl != 4) begin
      failures++;
      $display("FAIL poll_ctrl_reads got=%0d want=4", nctrl);
    end
    checks++;
    if (log_q.size() - base != 8) begin
      failures++;
      $display("FAIL poll_txn_count got=%0d want=8", log_q.size() - base);
    end else begin
      e = log_q[base + 2];
      checks++;
      if (e.dat !== 32'h2D08) begin
        failures++;
        $display("FAIL poll_ctrl_lsb got=%h want=2d08", e.dat);
      end
      e = log_q[base + 7];
      checks++;
      if ({e.adr, e.we} !== {5'h00, 1'b0}) begin
        failures++;
        $display("FAIL poll_last_rx0 got adr=%h we=%b want 00/0", e.adr, e.we);
      end
    end
    checks++;
    if ({rsp_err, rsp_dat} !== {1'b0, 32'h3C}) begin
      failures++;
      $display("FAIL poll_rsp got err=%b dat=%h want 0/3c", rsp_err, rsp_dat);
    end
    checks++;
    if (rsp_cycle - acc != 17) begin
      failures++;
      $display("FAIL poll_latency got=%0d want=17", rsp_cycle - acc);
    end
  endtask

  task automatic test_timeout();
    int base, rb, acc;
    noack_tx = 1'b1;
    base = log_q.size();
    rb = rsp_cnt;
    send_cmd(32'h11, 7'd8, 8'h01, 1'b0, acc);
    wait_rsp(rb, 200);
    checks++;
    if (log_q.size() - base != 1) begin
      failures++;
      $display("FAIL timeout_txn_count got=%0d want=1", log_q.size() - base);
    end
    checks++;
    if (last_len != 16) begin
      failures++;
      $display("FAIL timeout_cyc_len got=%0d want=16", last_len);
    end
    checks++;
    if ({rsp_err, rsp_dat} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL timeout_rsp got err=%b dat=%h want 1/0", rsp_err, rsp_dat);
    end
    noack_tx = 1'b0;
    base = log_q.size();
    rb = rsp_cnt;
    send_cmd(32'h5A, 7'd8, 8'h01, 1'b0, acc);
    wait_rsp(rb, 100);
    checks++;
    if (log_q.size() - base != 5) begin
      failures++;
      $display("FAIL recover_txn_count got=%0d want=5", log_q.size() - base);
    end
    checks++;
    if ({rsp_err, rsp_dat} !== {1'b0, 32'h5A}) begin
      failures++;
      $display("FAIL recover_rsp got err=%b dat=%h want 0/5a", rsp_err, rsp_dat);
    end
  endtask

  task automatic test_err_ss();
    int base, rb, acc;
    err_ss = 1'b1;
    base = log_q.size();
    rb = rsp_cnt;
    send_cmd(32'h77, 7'd8, 8'h04, 1'b0, acc);
    wait_rsp(rb, 100);
    checks++;
    if (log_q.size() - base != 2) begin
      failures++;
      $display("FAIL err_txn_count got=%0d want=2", log_q.size() - base);
    end else begin
      checks++;
      if (log_q[base + 1].adr !== 5'h18) begin
        failures++;
        $display("FAIL err_last_adr got=%h want=18", log_q[base + 1].adr);
      end
    end
    checks++;
    if ({rsp_err, rsp_dat} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL err_rsp got err=%b dat=%h want 1/0", rsp_err, rsp_dat);
    end
    err_ss = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base, rb, acc, n;
    busy_until = polls_seen + 100000;
    rb = rsp_cnt;
    send_cmd(32'h99, 7'd8, 8'h01, 1'b0, acc);
    n = 0;
    while (!(bus.wb_cyc_o === 1'b1 && bus.wb_we_o === 1'b0 && bus.wb_adr_o === 5'h10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL midrst_poll_seen got=none want=ctrl_read");
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_cyc_drop got=%b%b want=00", bus.wb_cyc_o, bus.wb_stb_o);
    end
    @(negedge clk);
    busy_until = polls_seen;
    base = log_q.size();
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (log_q.size() - base != 1) begin
      failures++;
      $display("FAIL midrst_txn_count got=%0d want=1", log_q.size() - base);
    end else begin
      checks++;
      if ({log_q[base].adr, log_q[base].we, log_q[base].dat} !== {5'h14, 1'b1, 32'h4}) begin
        failures++;
        $display("FAIL midrst_divider got adr=%h dat=%h want 14/4", log_q[base].adr, log_q[base].dat);
      end
    end
    checks++;
    if (rsp_cnt != rb) begin
      failures++;
      $display("FAIL midrst_no_rsp got=%0d want=0", rsp_cnt - rb);
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got=%b want=1", bus.cmd_ready_o);
    end
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_data_i  = 32'd0;
    bus.cmd_len_i   = 7'd0;
    bus.cmd_ss_i    = 8'd0;
    bus.cmd_lsb_i   = 1'b0;
    test_reset();
    test_basic();
    test_poll();
    test_timeout();
    test_err_ss();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
